// File: rtl/pe_vec_loader_pkg.sv
// Shared sizing and FSM state type for the PE vector loader.
// Lane count must match the pe_acc adder-tree width.
package pe_pkg;

  localparam int LANES  = 32;
  localparam int DATA_W = 16;
  localparam int VEC_W  = LANES * DATA_W;
  localparam int CNT_W  = $clog2(LANES) + 1;
  localparam int IDX_W  = $clog2(LANES);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } fill_state_t;

endpackage

// File: rtl/pe_vec_loader_lane_buf.sv
// LANES x DATA_W lane register file: indexed write, synchronous clear, flat read.
// Zero latency read; clear wins over write and has no backpressure.
module pe_lane_buf #(
  parameter int LANES  = 32,
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [$clog2(LANES)-1:0]   wr_idx,
  input  logic [DATA_W-1:0]          wr_dat,
  output logic [LANES*DATA_W-1:0]    rd_vec
);

  logic [DATA_W-1:0] mem [LANES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) mem[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k < LANES; k++) mem[k] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_dat;
    end
  end

  always_comb begin
    rd_vec = '0;
    for (int k = 0; k < LANES; k++) rd_vec[k*DATA_W +: DATA_W] = mem[k];
  end

endmodule

// File: rtl/pe_vec_loader.sv
// Packs neuron/weight beats into zero-padded lane vectors for the PE adder tree.
// Vector valid the cycle after its closing beat; one held vector, then in_ready drops.
module pe_vec_loader
  import pe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_neuron,
  input  logic [DATA_W-1:0] in_weight,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VEC_W-1:0]  out_neuron,
  output logic [VEC_W-1:0]  out_weight,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_last
);

  fill_state_t       state;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  hold_cnt;
  logic              hold_last;
  logic [VEC_W-1:0]  buf_n, buf_w, merge_n, merge_w;
  logic              accept, complete, slot_free, load_in, load_hold;
  logic              buf_wr, buf_clr;

  assign accept    = in_valid & in_ready;
  assign complete  = accept & ((idx == IDX_W'(LANES - 1)) | in_last);
  assign slot_free = !out_valid | out_ready;
  assign load_in   = (state == FILL) & complete & slot_free;
  assign load_hold = (state == HOLD) & slot_free;
  // A beat that goes straight to the output never lands in the buffer.
  assign buf_wr    = accept & !load_in;
  assign buf_clr   = load_in | load_hold;

  pe_lane_buf #(.LANES(LANES), .DATA_W(DATA_W)) u_buf_neuron (
    .clk(clk), .rst_n(rst_n), .clr(buf_clr), .wr_en(buf_wr),
    .wr_idx(idx), .wr_dat(in_neuron), .rd_vec(buf_n)
  );

  pe_lane_buf #(.LANES(LANES), .DATA_W(DATA_W)) u_buf_weight (
    .clk(clk), .rst_n(rst_n), .clr(buf_clr), .wr_en(buf_wr),
    .wr_idx(idx), .wr_dat(in_weight), .rd_vec(buf_w)
  );

  // Buffer contents with the in-flight beat overlaid at lane idx.
  always_comb begin
    merge_n = buf_n;
    merge_w = buf_w;
    for (int k = 0; k < LANES; k++) begin
      if (idx == IDX_W'(k)) begin
        merge_n[k*DATA_W +: DATA_W] = in_neuron;
        merge_w[k*DATA_W +: DATA_W] = in_weight;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      in_ready  <= 1'b1;
      idx       <= '0;
      hold_cnt  <= '0;
      hold_last <= 1'b0;
    end else begin
      if (accept) idx <= complete ? '0 : idx + IDX_W'(1);
      case (state)
        FILL: begin
          if (complete && !slot_free) begin
            state     <= HOLD;
            in_ready  <= 1'b0;
            hold_cnt  <= CNT_W'(idx) + CNT_W'(1);
            hold_last <= in_last;
          end
        end
        HOLD: begin
          if (slot_free) begin
            state    <= FILL;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= FILL;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_neuron <= '0;
      out_weight <= '0;
      out_count  <= '0;
      out_last   <= 1'b0;
    end else if (load_in) begin
      out_valid  <= 1'b1;
      out_neuron <= merge_n;
      out_weight <= merge_w;
      out_count  <= CNT_W'(idx) + CNT_W'(1);
      out_last   <= in_last;
    end else if (load_hold) begin
      out_valid  <= 1'b1;
      out_neuron <= buf_n;
      out_weight <= buf_w;
      out_count  <= hold_cnt;
      out_last   <= hold_last;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_vec_loader.sv
// Directed and randomized bench for pe_vec_loader against a queue-based vector model.
module tb_pe_vec_loader;
  import pe_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, in_last;
  logic [DATA_W-1:0] in_neuron, in_weight;
  logic              out_valid, out_ready, out_last;
  logic [VEC_W-1:0]  out_neuron, out_weight;
  logic [CNT_W-1:0]  out_count;

  always #5 clk = ~clk;

  pe_vec_loader dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_neuron(in_neuron), .in_weight(in_weight), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_neuron(out_neuron), .out_weight(out_weight),
    .out_count(out_count), .out_last(out_last)
  );

  typedef struct {
    logic [VEC_W-1:0] n;
    logic [VEC_W-1:0] w;
    int               cnt;
    bit               last;
  } vec_t;

  vec_t             exp_q[$];
  vec_t             cur;
  int               checks = 0;
  int               failures = 0;
  int               delivered = 0;
  bit               rand_rdy = 1'b0;
  logic [VEC_W-1:0] got_n, got_w;

  task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur.n = '0;
    cur.w = '0;
    cur.cnt = 0;
    cur.last = 1'b0;
  endtask

  // One clock: check outputs against the model, apply both handshakes, advance.
  task automatic step();
    vec_t f;
    bit   hs, acc;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    chk("out_valid", VEC_W'(out_valid), VEC_W'(exp_q.size() > 0));
    chk("in_ready", VEC_W'(in_ready), VEC_W'(exp_q.size() < 2));
    if (out_valid === 1'b1 && exp_q.size() > 0) begin
      f = exp_q[0];
      chk("out_neuron", out_neuron, f.n);
      chk("out_weight", out_weight, f.w);
      chk("out_count", VEC_W'(out_count), VEC_W'(f.cnt));
      chk("out_last", VEC_W'(out_last), VEC_W'(f.last));
    end
    hs  = (out_valid === 1'b1) && (out_ready === 1'b1);
    acc = (in_valid === 1'b1) && (in_ready === 1'b1);
    if (hs && exp_q.size() > 0) begin
      got_n = out_neuron;
      got_w = out_weight;
      void'(exp_q.pop_front());
      delivered++;
    end
    if (acc) begin
      cur.n[cur.cnt*DATA_W +: DATA_W] = in_neuron;
      cur.w[cur.cnt*DATA_W +: DATA_W] = in_weight;
      cur.cnt++;
      if (cur.cnt == LANES || in_last) begin
        cur.last = in_last;
        exp_q.push_back(cur);
        cur.n = '0;
        cur.w = '0;
        cur.cnt = 0;
        cur.last = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] n, input logic [DATA_W-1:0] w, input bit last);
    bit taken = 1'b0;
    int t = 0;
    in_valid  = 1'b1;
    in_neuron = n;
    in_weight = w;
    in_last   = last;
    while (!taken && t < 200) begin
      taken = (in_ready === 1'b1);
      step();
      t++;
    end
    chk("beat_accepted", VEC_W'(taken), VEC_W'(1));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int     d0;
    longint sum;
    int     len;

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_neuron = '0; in_weight = '0; out_ready = 1'b0;
    model_reset();
    #2;
    chk("rst_out_valid", VEC_W'(out_valid), VEC_W'(0));
    chk("rst_out_neuron", out_neuron, '0);
    chk("rst_out_weight", out_weight, '0);
    chk("rst_out_count", VEC_W'(out_count), VEC_W'(0));
    chk("rst_out_last", VEC_W'(out_last), VEC_W'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full vector of neuron=i, weight=1; tree sum is 0+1+...+31.
    out_ready = 1'b1;
    delivered = 0;
    for (int i = 0; i < LANES; i++) send_beat(DATA_W'(i), DATA_W'(1), 1'b0);
    idle(1);
    chk("t1_delivered", VEC_W'(delivered), VEC_W'(1));
    sum = 0;
    for (int k = 0; k < LANES; k++)
      sum += longint'($signed(got_n[k*DATA_W +: DATA_W])) * longint'($signed(got_w[k*DATA_W +: DATA_W]));
    chk("t1_pe_acc_sum", VEC_W'(sum), VEC_W'(496));

    // Short vector closed by in_last.
    for (int i = 0; i < 5; i++) send_beat(16'($urandom), 16'($urandom), i == 4);
    idle(2);

    // All-ones vector followed by a short one: upper lanes must be clean zeros.
    for (int i = 0; i < LANES; i++) send_beat(16'hFFFF, 16'hFFFF, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(16'($urandom), 16'($urandom), i == 2);
    idle(2);
    chk("t3_pad_neuron", got_n >> (3 * DATA_W), '0);
    chk("t3_pad_weight", got_w >> (3 * DATA_W), '0);

    // Downstream stalled: one vector on the output, one held, then in_ready low.
    out_ready = 1'b0;
    d0 = delivered;
    for (int i = 0; i < 2 * LANES; i++) send_beat(16'($urandom), 16'($urandom), 1'b0);
    idle(3);
    chk("t4_in_ready_hold", VEC_W'(in_ready), VEC_W'(0));
    out_ready = 1'b1;
    idle(4);
    chk("t4_delivered", VEC_W'(delivered - d0), VEC_W'(2));
    chk("t4_in_ready_back", VEC_W'(in_ready), VEC_W'(1));

    // Streaming: three vectors back to back with the slot always free.
    d0 = delivered;
    for (int i = 0; i < 3 * LANES; i++) send_beat(16'($urandom), 16'($urandom), 1'b0);
    idle(1);
    chk("t5_delivered", VEC_W'(delivered - d0), VEC_W'(3));

    // Reset in the middle of a partial vector with a vector waiting on the output.
    out_ready = 1'b0;
    for (int i = 0; i < LANES + 10; i++) send_beat(16'($urandom), 16'($urandom), 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", VEC_W'(out_valid), VEC_W'(0));
    chk("t6_out_count", VEC_W'(out_count), VEC_W'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    d0 = delivered;
    for (int i = 0; i < LANES; i++) send_beat(16'($urandom), 16'($urandom), 1'b0);
    idle(2);
    chk("t6_delivered", VEC_W'(delivered - d0), VEC_W'(1));

    // Random lengths, random gaps and random downstream stalls.
    rand_rdy = 1'b1;
    len = 0;
    for (int i = 0; i < 300; i++) begin
      len++;
      send_beat(16'($urandom), 16'($urandom), ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
